// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states,
// store strobe patterns and the store lane-replication helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H_LO = 4'b0011;
   localparam logic [3:0] STRB_H_HI = 4'b1100;
   localparam logic [3:0] STRB_W    = 4'b1111;

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B:    store_strb = STRB_B << off;
         F3_H:    store_strb = off[1] ? STRB_H_HI : STRB_H_LO;
         F3_W:    store_strb = STRB_W;
         default: store_strb = STRB_NONE;
      endcase
   endfunction

   // Replicate the store operand across every lane it could land in
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         F3_B:    store_wdata = {4{wd[7:0]}};
         F3_H:    store_wdata = {2{wd[15:0]}};
         default: store_wdata = wd;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Word-wide req/ack data-memory port between the LSU (master) and memory (slave).
interface lsu_mem_if_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = 8'(i_word >> {i_off, 3'b000});
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_result = i_word;
      case (i_funct3)
         F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_result = {24'd0, w_byte};
         F3_H:    o_result = {{16{w_half[15]}}, w_half};
         F3_HU:   o_result = {16'd0, w_half};
         default: o_result = i_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns an ALU effective address into one req/ack memory
// transaction, stalling the core until the access completes or faults.
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [31:0]       WriteData,
   output logic              Stall,
   output logic [31:0]       ReadData,
   output logic              Done,
   output logic              Fault,
   lsu_mem_if_if.master      mem
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   lsu_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_wstrb;
   logic [31:0]       r_wdata;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [31:0]       r_rdata;
   logic              r_done;
   logic              r_fault;

   logic              w_access;
   logic              w_we;
   logic [1:0]        w_off;
   logic              w_illegal;
   logic              w_misalign;
   logic              w_timeout;
   logic [31:0]       w_load_val;

   assign w_access = MemRead | MemWrite;
   assign w_we     = MemWrite;
   assign w_off    = ALUResult[1:0];

   // Unsigned loads have no store counterpart
   always_comb begin
      w_illegal = 1'b1;
      case (funct3)
         F3_B, F3_H, F3_W: w_illegal = 1'b0;
         F3_BU, F3_HU:     w_illegal = w_we;
         default:          w_illegal = 1'b1;
      endcase
   end

   assign w_misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && w_off[0]) ||
                       ((funct3 == F3_W) && (w_off != 2'b00));
   assign w_timeout  = (TIMEOUT != 0) && (r_cnt == TO_LAST);

   lsu_load_extend u_load_extend (
      .i_word   (mem.mem_rdata),
      .i_off    (r_off),
      .i_funct3 (r_funct3),
      .o_result (w_load_val)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_mem_req <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wstrb   <= '0;
         r_wdata   <= '0;
         r_funct3  <= '0;
         r_off     <= '0;
         r_rdata   <= '0;
         r_done    <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_illegal || w_misalign) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_fault <= 1'b1;
                     r_rdata <= '0;
                  end else begin
                     r_state   <= REQ;
                     r_mem_req <= 1'b1;
                     r_cnt     <= '0;
                     r_we      <= w_we;
                     r_addr    <= {ALUResult[ADDR_W-1:2], 2'b00};
                     r_funct3  <= funct3;
                     r_off     <= w_off;
                     r_wstrb   <= w_we ? store_strb(funct3, w_off) : STRB_NONE;
                     r_wdata   <= store_wdata(funct3, WriteData);
                  end
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  r_state   <= DONE;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_cnt     <= '0;
                  if (!r_we) r_rdata <= w_load_val;
               end else if (w_timeout) begin
                  r_state   <= DONE;
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_fault   <= 1'b1;
                  r_rdata   <= '0;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Gated by reset so an aborted access releases the core immediately
   assign Stall = !reset && (((r_state == IDLE) && w_access) || (r_state == REQ));

   assign ReadData      = r_rdata;
   assign Done          = r_done;
   assign Fault         = r_fault;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wstrb = r_wstrb;
   assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: stores, loads, faults, timeout and reset abort
// against hand-computed expected values.
module tb_lsu_mem_if;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult, WriteData;
   logic        Stall, Done, Fault;
   logic [31:0] ReadData;

   int n_checks = 0;
   int n_errors = 0;

   // Results of the most recent run_access
   int          res_stall, res_req;
   logic        res_done, res_fault, res_we;
   logic [31:0] res_addr, res_wdata, res_rd;
   logic [3:0]  res_strb;

   lsu_mem_if_if #(.ADDR_W(32)) bus ();

   lsu_mem_if #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .funct3    (funct3),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .Stall     (Stall),
      .ReadData  (ReadData),
      .Done      (Done),
      .Fault     (Fault),
      .mem       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that leaves DONE.
   // ack_n = REQ cycle in which mem_ack is pulsed (0 = never).
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_n, input logic [31:0] rdata_v);
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
      res_stall = 0; res_req = 0; res_done = 1'b0; res_fault = 1'b0; res_rd = '0;
      res_addr = '0; res_wdata = '0; res_strb = '0; res_we = 1'b0;
      for (int c = 0; c < 40 && !res_done; c++) begin
         @(negedge clk);
         if (Stall) res_stall++;
         if (Done) begin
            res_done  = 1'b1;
            res_fault = Fault;
            res_rd    = ReadData;
         end
         if (bus.mem_req) begin
            res_req++;
            if (res_req == 1) begin
               res_addr = bus.mem_addr; res_strb = bus.mem_wstrb;
               res_wdata = bus.mem_wdata; res_we = bus.mem_we;
            end
            if (res_req == ack_n) begin
               bus.mem_ack = 1'b1;
               bus.mem_rdata = rdata_v;
            end
         end
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
      end
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic quiet_cycle(input string tag);
      @(negedge clk);
      chk({tag, "_done"}, 32'(Done), 32'd0);
      chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
      ALUResult = '0; WriteData = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_fault", 32'(Fault), 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_strb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // SW with ack in the second REQ cycle
      run_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 2, 32'h0);
      chk("sw_done", 32'(res_done), 32'd1);
      chk("sw_fault", 32'(res_fault), 32'd0);
      chk("sw_stall", 32'(res_stall), 32'd3);
      chk("sw_reqcyc", 32'(res_req), 32'd2);
      chk("sw_addr", res_addr, 32'h100);
      chk("sw_strb", 32'(res_strb), 32'hF);
      chk("sw_wdata", res_wdata, 32'hDEADBEEF);
      chk("sw_we", 32'(res_we), 32'd1);
      quiet_cycle("sw_after");

      // SB to 0x103, then back-to-back SH to 0x102
      run_access(1'b0, 1'b1, F3_B, 32'h103, 32'h000000A5, 1, 32'h0);
      chk("sb_done", 32'(res_done), 32'd1);
      chk("sb_addr", res_addr, 32'h100);
      chk("sb_strb", 32'(res_strb), 32'h8);
      chk("sb_wdata", res_wdata, 32'hA5A5A5A5);
      run_access(1'b0, 1'b1, F3_H, 32'h102, 32'h00001234, 1, 32'h0);
      chk("sh_done", 32'(res_done), 32'd1);
      chk("sh_stall", 32'(res_stall), 32'd2);
      chk("sh_strb", 32'(res_strb), 32'hC);
      chk("sh_wdata", res_wdata, 32'h12341234);

      // Loads from the word 0x80F17F01
      run_access(1'b1, 1'b0, F3_B, 32'h1, 32'h0, 1, 32'h80F17F01);
      chk("lb1_done", 32'(res_done), 32'd1);
      chk("lb1_val", res_rd, 32'h0000007F);
      chk("lb1_strb", 32'(res_strb), 32'h0);
      chk("lb1_we", 32'(res_we), 32'd0);
      chk("lb1_addr", res_addr, 32'h0);
      run_access(1'b1, 1'b0, F3_B, 32'h2, 32'h0, 1, 32'h80F17F01);
      chk("lb2_val", res_rd, 32'hFFFFFFF1);
      run_access(1'b1, 1'b0, F3_BU, 32'h3, 32'h0, 3, 32'h80F17F01);
      chk("lbu3_val", res_rd, 32'h00000080);
      chk("lbu3_fault", 32'(res_fault), 32'd0);
      run_access(1'b1, 1'b0, F3_H, 32'h2, 32'h0, 1, 32'h80F17F01);
      chk("lh2_val", res_rd, 32'hFFFF80F1);
      run_access(1'b1, 1'b0, F3_HU, 32'h0, 32'h0, 1, 32'h80F17F01);
      chk("lhu0_val", res_rd, 32'h00007F01);
      run_access(1'b1, 1'b0, F3_W, 32'h4, 32'h0, 1, 32'h80F17F01);
      chk("lw_val", res_rd, 32'h80F17F01);

      // A store leaves the previous load result intact
      run_access(1'b0, 1'b1, F3_W, 32'h8, 32'h55555555, 1, 32'hFFFFFFFF);
      chk("st_keep_rd", ReadData, 32'h80F17F01);

      // Misaligned and illegal accesses fault without a bus request
      run_access(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 1, 32'h0);
      chk("lwmis_done", 32'(res_done), 32'd1);
      chk("lwmis_fault", 32'(res_fault), 32'd1);
      chk("lwmis_req", 32'(res_req), 32'd0);
      chk("lwmis_stall", 32'(res_stall), 32'd1);
      chk("lwmis_rd", res_rd, 32'd0);
      run_access(1'b1, 1'b0, F3_H, 32'h101, 32'h0, 1, 32'h0);
      chk("lhmis_fault", 32'(res_fault), 32'd1);
      chk("lhmis_req", 32'(res_req), 32'd0);
      run_access(1'b0, 1'b1, F3_BU, 32'h0, 32'h0, 1, 32'h0);
      chk("sbu_fault", 32'(res_fault), 32'd1);
      chk("sbu_req", 32'(res_req), 32'd0);
      run_access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0);
      chk("f3_011_fault", 32'(res_fault), 32'd1);

      // Good load to set ReadData, then a timeout must zero it
      run_access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1, 32'h12345678);
      chk("pre_to_rd", res_rd, 32'h12345678);
      run_access(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 0, 32'h0);
      chk("to_done", 32'(res_done), 32'd1);
      chk("to_fault", 32'(res_fault), 32'd1);
      chk("to_reqcyc", 32'(res_req), 32'd4);
      chk("to_stall", 32'(res_stall), 32'd5);
      chk("to_rd", res_rd, 32'd0);
      // Stray ack after the timeout
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("stray_stall", 32'(Stall), 32'd0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      quiet_cycle("stray_after");
      chk("stray_rd", ReadData, 32'd0);

      // Reset during the second REQ cycle
      MemRead = 1'b1; funct3 = F3_W; ALUResult = 32'h200;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_req1", 32'(bus.mem_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort_req", 32'(bus.mem_req), 32'd0);
      chk("abort_stall", 32'(Stall), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBADBAD00;
      @(negedge clk);
      chk("abort_ack_done", 32'(Done), 32'd0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      quiet_cycle("abort_after");

      // Read and write together: write wins
      run_access(1'b1, 1'b1, F3_W, 32'h300, 32'h11223344, 1, 32'hFFFFFFFF);
      chk("rw_done", 32'(res_done), 32'd1);
      chk("rw_we", 32'(res_we), 32'd1);
      chk("rw_strb", 32'(res_strb), 32'hF);
      chk("rw_wdata", res_wdata, 32'h11223344);
      chk("rw_rd", ReadData, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
